mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_SIZE, default 10, sets the scratchpad address width.
REQ-002 Parameter WORD_SIZE, default 16, sets the scratchpad data width.
REQ-003 Parameter MAX_BURST, default 64, sets the beat limit per grant (used only under MEM_ARB_STARVE_GUARD_EN).
REQ-004 Port clk, input, 1, the single clock; all state on rising edge.
REQ-005 Port reset, input, 1, asynchronous, active-high reset.
REQ-006 Port req, input, [2:0], per-requester access request: 0 = SPI load, 1 = result writeback, 2 = SPI readback.
REQ-007 Port we, input, [2:0], per-requester write enable (1 = write, 0 = read), sampled with req.
REQ-008 Port addr, input, [2:0][ADDR_SIZE-1:0], per-requester word address.
REQ-009 Port wdata, input, [2:0][WORD_SIZE-1:0], per-requester write data.
REQ-010 Port last, input, [2:0], per-requester flag marking the final beat of a burst.
REQ-011 Port gnt, output, [2:0], one-hot-or-zero grant.
REQ-012 Port rvalid, output, [2:0], per-requester read-data valid.
REQ-013 Port rdata, output, WORD_SIZE, shared read data, equal to mem_rdata.
REQ-014 Ports mem_en, mem_we (1), mem_addr (ADDR_SIZE), mem_wdata (WORD_SIZE), outputs to the memory.
REQ-015 Port mem_rdata, input, WORD_SIZE, memory read data with 1-cycle latency.

Function
REQ-016 FSM states are IDLE and BUSY, with an owner register (2 bits) and a round-robin pointer rr (2 bits, values 0..2).
REQ-017 In IDLE with any req bit high at edge N, the block shall select the first requester with req high, searching rr, rr+1, rr+2 (mod 3), and shall enter BUSY with gnt[owner]=1 from cycle N+1.
REQ-018 In BUSY, a beat is accepted in every cycle where req[owner]=1.
REQ-019 For an accepted beat, mem_en=1 and mem_we/mem_addr/mem_wdata equal the owner's we/addr/wdata, driven combinationally in the same cycle.
REQ-020 In every other cycle, mem_en=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-021 An accepted read (we=0) at cycle N shall assert rvalid[owner] for exactly cycle N+1, with rdata=mem_rdata.
REQ-022 rvalid shall follow the read issuer even if the grant has been released at N+1.
REQ-023 Release condition: an accepted beat with last[owner]=1, or req[owner]=0 while BUSY.
REQ-024 On release, the FSM returns to IDLE next cycle with gnt=0, and sets rr=(owner+1) mod 3.
REQ-025 Every grant is followed by one idle bubble cycle.
REQ-026 A beat counter (8 bits) clears on grant and increments per accepted beat, saturating at 255.
REQ-027 Requests that arrive while BUSY wait; they are never dropped.
REQ-028 gnt shall never have more than one bit set.

Reset
REQ-029 While reset=1, asynchronously: state=IDLE, owner=0, rr=0, gnt=0, rvalid=0, beat counter=0.
REQ-030 While reset=1, mem_en=0 and mem_we=0.
REQ-031 Reset asserted mid-burst shall abort the burst with no further memory access, and shall suppress any pending rvalid.
REQ-032 After reset deasserts, arbitration restarts from rr=0.

Configuration
REQ-033 With macro MEM_ARB_STARVE_GUARD_EN defined: when the beat counter reaches MAX_BURST on an accepted beat and any other req bit is high, that beat shall be treated as last (forced release).
REQ-034 With MEM_ARB_STARVE_GUARD_EN defined and no other requester pending, the grant continues past MAX_BURST.
REQ-035 Without MEM_ARB_STARVE_GUARD_EN: bursts are unbounded, MAX_BURST is ignored, and the guard logic is absent.

Verification
REQ-036 Single write: req[0]=1, we=1, addr=0x005, wdata=0xBEEF, last=1 -> gnt[0] on the next cycle, one mem_en cycle writing 0xBEEF to 0x005, gnt=0 the cycle after.
REQ-037 Read latency: requester 2 reads 0x010 where memory holds 0x1234 -> rvalid[2]=1 with rdata=0x1234 exactly one cycle after the accepted beat.
REQ-038 Round-robin: req=3'b111 held, single-beat bursts -> grant order 0,1,2,0 with one bubble between grants.
REQ-039 Guard: macro on, MAX_BURST=4, requester 1 issues an 8-beat burst while req[0]=1 -> 4 beats, release, then gnt[0]; macro off -> all 8 beats before release.
REQ-040 Reset mid-burst: reset asserted on the 3rd beat of a 5-beat read burst -> gnt=0, mem_en=0 and rvalid=0 immediately; after reset, req[1] is granted first with rr=0.
REQ-041 Early drop: owner deasserts req without last after 2 beats -> release, IDLE next cycle, rr advances past the owner.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Three-way round-robin burst arbiter for a single-port scratchpad
//            with 1-cycle read latency. Optional burst cap when the macro
//            MEM_ARB_STARVE_GUARD_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_SIZE = 10,
    parameter int WORD_SIZE = 16,
    parameter int MAX_BURST = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [2:0]                     req,
    input  logic [2:0]                     we,
    input  logic [2:0][ADDR_SIZE-1:0]      addr,
    input  logic [2:0][WORD_SIZE-1:0]      wdata,
    input  logic [2:0]                     last,
    output logic [2:0]                     gnt,
    output logic [2:0]                     rvalid,
    output logic [WORD_SIZE-1:0]           rdata,
    output logic                           mem_en,
    output logic                           mem_we,
    output logic [ADDR_SIZE-1:0]           mem_addr,
    output logic [WORD_SIZE-1:0]           mem_wdata,
    input  logic [WORD_SIZE-1:0]           mem_rdata
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     r_state_q, w_state_d;
    logic [1:0] r_owner_q, w_owner_d;
    logic [1:0] r_rr_q, w_rr_d;
    logic [7:0] r_beat_cnt_q, w_beat_cnt_d;
    logic [2:0] r_rvalid_q, w_rvalid_d;

    logic [2:0] w_owner_oh;
    logic [1:0] w_pick;
    logic [7:0] w_beat_inc;
    logic       w_accept;
    logic       w_force;
    logic       w_release;

    // Slot at distance offset from base in the 0..2 rotation.
    function automatic logic [1:0] rr_slot(input logic [1:0] base, input logic [1:0] offset);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, offset};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

    always_comb begin
        w_owner_oh = 3'b000;
        case (r_owner_q)
            2'd0:    w_owner_oh = 3'b001;
            2'd1:    w_owner_oh = 3'b010;
            2'd2:    w_owner_oh = 3'b100;
            default: w_owner_oh = 3'b000;
        endcase

        // Scan from farthest to nearest so the nearest pending slot wins.
        w_pick = r_rr_q;
        for (int i = 2; i >= 0; i--) begin
            if (req[rr_slot(r_rr_q, 2'(i))]) begin
                w_pick = rr_slot(r_rr_q, 2'(i));
            end
        end

        w_accept   = (r_state_q == BUSY) && req[r_owner_q];
        w_beat_inc = (r_beat_cnt_q == 8'hFF) ? 8'hFF : r_beat_cnt_q + 8'd1;

`ifdef MEM_ARB_STARVE_GUARD_EN
        w_force = w_accept && (int'({24'd0, w_beat_inc}) >= MAX_BURST) && (|(req & ~w_owner_oh));
`else
        w_force = 1'b0;
`endif

        w_release = (r_state_q == BUSY) &&
                    (!req[r_owner_q] || (w_accept && (last[r_owner_q] || w_force)));

        gnt       = (r_state_q == BUSY) ? w_owner_oh : 3'b000;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_accept) begin
            mem_en    = 1'b1;
            mem_we    = we[r_owner_q];
            mem_addr  = addr[r_owner_q];
            mem_wdata = wdata[r_owner_q];
        end

        w_state_d    = r_state_q;
        w_owner_d    = r_owner_q;
        w_rr_d       = r_rr_q;
        w_beat_cnt_d = r_beat_cnt_q;
        w_rvalid_d   = 3'b000;

        case (r_state_q)
            IDLE: begin
                if (|req) begin
                    w_state_d    = BUSY;
                    w_owner_d    = w_pick;
                    w_beat_cnt_d = 8'd0;
                end
            end
            BUSY: begin
                if (w_accept) begin
                    w_beat_cnt_d = w_beat_inc;
                end
                if (w_release) begin
                    w_state_d = IDLE;
                    w_rr_d    = rr_slot(r_owner_q, 2'd1);
                end
            end
            default: w_state_d = IDLE;
        endcase

        // Read data returns one cycle later; tag it with the issuer, not the grant.
        if (w_accept && !we[r_owner_q]) begin
            w_rvalid_d = w_owner_oh;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q    <= IDLE;
            r_owner_q    <= 2'd0;
            r_rr_q       <= 2'd0;
            r_beat_cnt_q <= 8'd0;
            r_rvalid_q   <= 3'b000;
        end else begin
            r_state_q    <= w_state_d;
            r_owner_q    <= w_owner_d;
            r_rr_q       <= w_rr_d;
            r_beat_cnt_q <= w_beat_cnt_d;
            r_rvalid_q   <= w_rvalid_d;
        end
    end

    assign rvalid = r_rvalid_q;
    assign rdata  = mem_rdata;

endmodule
`default_nettype wire
